// File: rtl/text_line_display_pkg.sv
// Shared constants for the text line display: ASCII codes, colours, glyph cell size.
package text_line_display_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UZ    = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;

  // Distance from a lowercase letter to its uppercase form
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/ascii_rom.sv
// Glyph ROM: address {code[6:0], row[3:0]}, one-cycle synchronous read, MSB = leftmost pixel.
// Reduced glyph set: 'H' and 'I' are drawn, other uppercase letters show a box, everything else is blank.
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);

  logic [6:0] w_code;
  logic [3:0] w_row;
  logic [7:0] w_bits;

  assign w_code = i_addr[10:4];
  assign w_row  = i_addr[3:0];

  // Glyph row lookup
  always_comb begin
    w_bits = 8'h00;
    if (w_code == 7'h48) begin
      if ((w_row >= 4'd2 && w_row <= 4'd6) || (w_row >= 4'd8 && w_row <= 4'd12)) w_bits = 8'hC6;
      else if (w_row == 4'd7) w_bits = 8'hFE;
    end else if (w_code == 7'h49) begin
      if (w_row == 4'd2 || w_row == 4'd12) w_bits = 8'h3C;
      else if (w_row >= 4'd3 && w_row <= 4'd11) w_bits = 8'h18;
    end else if (w_code >= 7'h41 && w_code <= 7'h5A) begin
      if (w_row == 4'd2 || w_row == 4'd13) w_bits = 8'h7E;
      else if (w_row >= 4'd3 && w_row <= 4'd12) w_bits = 8'h42;
    end
  end

  // Synchronous read
  always_ff @(posedge clk) begin
    o_data <= w_bits;
  end

endmodule

// File: rtl/text_line_display.sv
// One line of scaled 8x16 glyphs with a blinking underline cursor, fed by a valid/ready char stream.
module text_line_display
  import text_line_display_pkg::*;
#(
  parameter int unsigned NUM_CHARS  = 16,
  parameter int unsigned X0         = 256,
  parameter int unsigned Y0         = 208,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter logic [11:0] FG         = COLOR_BLACK,
  parameter logic [11:0] BG         = COLOR_WHITE,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               video_on,
  input  logic [9:0]                         x,
  input  logic [9:0]                         y,
  input  logic                               char_valid,
  input  logic [7:0]                         char_data,
  output logic                               char_ready,
  output logic [$clog2(NUM_CHARS + 1)-1:0]   cursor,
  output logic                               full,
  output logic [11:0]                        rgb
);

  localparam int unsigned CW       = $clog2(NUM_CHARS + 1);
  localparam int unsigned IW       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned LINE_W   = NUM_CHARS * (CHAR_W << SCALE_LOG2);
  localparam int unsigned LINE_H   = CHAR_H << SCALE_LOG2;
  localparam logic [CW-1:0] CUR_MAX    = CW'(NUM_CHARS);
  localparam logic [IW-1:0] LAST_CELL  = IW'(NUM_CHARS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_sweep_idx, w_sweep_nxt;
  logic [CW-1:0] r_cursor, w_cursor_nxt;
  logic [6:0]    r_cells [NUM_CHARS];
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;

  logic          w_full, w_xfer, w_we;
  logic [IW-1:0] w_waddr;
  logic [6:0]    w_wdata;
  logic [7:0]    w_code;

  assign char_ready = (r_state == S_IDLE);
  assign w_xfer     = char_valid & char_ready;
  assign w_full     = (r_cursor == CUR_MAX);
  assign full       = w_full;
  assign cursor     = r_cursor;

  // Next state, cursor and buffer write port
  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_nxt  = r_sweep_idx;
    w_cursor_nxt = r_cursor;
    w_we         = 1'b0;
    w_waddr      = r_sweep_idx;
    w_wdata      = ASCII_SPACE[6:0];
    w_code       = char_data;
    if (char_data >= ASCII_LA && char_data <= ASCII_LZ) w_code = char_data - CASE_OFFSET;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_sweep_idx == LAST_CELL) begin
          w_state_nxt = S_IDLE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_idx + 1'b1;
        end
      end
      S_IDLE: begin
        if (w_xfer) begin
          if ((w_code >= ASCII_UA && w_code <= ASCII_UZ) || w_code == ASCII_SPACE) begin
            if (!w_full) begin
              w_we         = 1'b1;
              w_waddr      = IW'(r_cursor);
              w_wdata      = w_code[6:0];
              w_cursor_nxt = r_cursor + 1'b1;
            end
          end else if (w_code == ASCII_BS) begin
            if (r_cursor != '0) begin
              w_we         = 1'b1;
              w_waddr      = IW'(r_cursor - 1'b1);
              w_cursor_nxt = r_cursor - 1'b1;
            end
          end else if (w_code == ASCII_CR) begin
            w_cursor_nxt = '0;
            w_sweep_nxt  = '0;
            w_state_nxt  = S_CLEAR;
          end
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // State, sweep index and cursor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_sweep_idx <= '0;
      r_cursor    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
      r_cursor    <= w_cursor_nxt;
    end
  end

  // Cell buffer write; contents are initialised by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (w_we && !reset) r_cells[w_waddr] <= w_wdata;
  end

  // Cursor blink; any accepted character restarts the visible phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_xfer) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Stage 0: pixel geometry and glyph address
  logic [31:0]   w_dx, w_dy;
  logic          w_in_line, w_cursor_hit;
  logic [CW-1:0] w_cell;
  logic [2:0]    w_col;
  logic [3:0]    w_row;
  logic [6:0]    w_cell_char;
  logic [7:0]    w_rom_data;

  assign w_dx      = 32'(x) - X0;
  assign w_dy      = 32'(y) - Y0;
  assign w_in_line = (32'(x) >= X0) && (32'(x) < X0 + LINE_W) &&
                     (32'(y) >= Y0) && (32'(y) < Y0 + LINE_H);
  assign w_cell    = CW'(w_dx >> (3 + SCALE_LOG2));
  assign w_col     = 3'(w_dx >> SCALE_LOG2);
  assign w_row     = 4'(w_dy >> SCALE_LOG2);
  assign w_cell_char  = w_in_line ? r_cells[IW'(w_cell)] : ASCII_SPACE[6:0];
  assign w_cursor_hit = (w_cell == r_cursor) && !w_full && (w_row >= 4'd14) && r_blink;

  ascii_rom u_rom (
    .clk    (clk),
    .i_addr ({w_cell_char, w_row}),
    .o_data (w_rom_data)
  );

  // Stage 1: side-band aligned with the ROM read
  logic [2:0] r_col_d;
  logic       r_in_line_d, r_video_d, r_cursor_hit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_d        <= '0;
      r_in_line_d    <= 1'b0;
      r_video_d      <= 1'b0;
      r_cursor_hit_d <= 1'b0;
    end else begin
      r_col_d        <= w_col;
      r_in_line_d    <= w_in_line;
      r_video_d      <= video_on;
      r_cursor_hit_d <= w_cursor_hit;
    end
  end

  // Stage 2: colour select
  logic w_lit;
  assign w_lit = w_rom_data[3'd7 - r_col_d] | r_cursor_hit_d;

  always_ff @(posedge clk) begin
    if (reset)                     rgb <= '0;
    else if (!r_video_d)           rgb <= '0;
    else if (r_in_line_d && w_lit) rgb <= FG;
    else                           rgb <= BG;
  end

endmodule

// File: tb/tb_text_line_display.sv
// Directed bench for text_line_display: default instance plus a scaled, fast-blink instance.
module tb_text_line_display;

  localparam int X0 = 256;
  localparam int Y0 = 208;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b1, video_on_a = 1'b1, valid_a = 1'b0, ready_a, full_a;
  logic [9:0]  x_a = 10'(X0), y_a = 10'(Y0);
  logic [7:0]  data_a = 8'h00;
  logic [4:0]  cursor_a;
  logic [11:0] rgb_a;

  logic        reset_b = 1'b1, video_on_b = 1'b1, valid_b = 1'b0, ready_b, full_b;
  logic [9:0]  x_b = 10'(X0), y_b = 10'(Y0);
  logic [7:0]  data_b = 8'h00;
  logic [4:0]  cursor_b;
  logic [11:0] rgb_b;

  text_line_display u_dut_a (
    .clk(clk), .reset(reset_a), .video_on(video_on_a), .x(x_a), .y(y_a),
    .char_valid(valid_a), .char_data(data_a), .char_ready(ready_a),
    .cursor(cursor_a), .full(full_a), .rgb(rgb_a)
  );

  text_line_display #(.SCALE_LOG2(1), .BLINK_DIV(4)) u_dut_b (
    .clk(clk), .reset(reset_b), .video_on(video_on_b), .x(x_b), .y(y_b),
    .char_valid(valid_b), .char_data(data_b), .char_ready(ready_b),
    .cursor(cursor_b), .full(full_b), .rgb(rgb_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready must stay low for the whole sweep and come back on the 16th edge
  task automatic wait_sweep_a(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check_eq(tag, 32'(ready_a), 32'(k == 16));
    end
    valid_a = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] c);
    int guard = 0;
    while (!ready_a && guard < 100) begin
      tick(1);
      guard++;
    end
    if (!ready_a) check_eq("ready_timeout_a", 32'(ready_a), 32'd1);
    valid_a = 1'b1;
    data_a  = c;
    tick(1);
    valid_a = 1'b0;
  endtask

  task automatic probe_a(input string tag, input int px, input int py, input logic [11:0] exp);
    x_a = 10'(px);
    y_a = 10'(py);
    tick(2);
    check_eq(tag, 32'(rgb_a), 32'(exp));
  endtask

  task automatic probe_b(input string tag, input int px, input int py, input logic [11:0] exp);
    x_b = 10'(px);
    y_b = 10'(py);
    tick(2);
    check_eq(tag, 32'(rgb_b), 32'(exp));
  endtask

  initial begin
    // Reset state, with a character already offered
    valid_a = 1'b1;
    data_a  = 8'h51;
    tick(3);
    check_eq("rst_rgb",    32'(rgb_a),    32'h0);
    check_eq("rst_ready",  32'(ready_a),  32'h0);
    check_eq("rst_cursor", 32'(cursor_a), 32'h0);
    check_eq("rst_full",   32'(full_a),   32'h0);

    // Clear sweep after reset release
    reset_a = 1'b0;
    wait_sweep_a("clr_ready");
    check_eq("clr_cursor", 32'(cursor_a), 32'h0);
    probe_a("blank_first", X0,       Y0,      12'hFFF);
    probe_a("blank_last",  X0 + 127, Y0 + 13, 12'hFFF);
    probe_a("cursor_ul0",  X0 + 3,   Y0 + 15, 12'h000);

    // "HI": H rows 2-6/8-12 = C6, row 7 = FE; I row 2 = 3C, rows 3-11 = 18
    send_a(8'h48);
    send_a(8'h49);
    check_eq("hi_cursor", 32'(cursor_a), 32'd2);
    probe_a("h_r7_c0", X0 + 0,  Y0 + 7,  12'h000);
    probe_a("h_r7_c7", X0 + 7,  Y0 + 7,  12'hFFF);
    probe_a("h_r2_c1", X0 + 1,  Y0 + 2,  12'h000);
    probe_a("h_r2_c3", X0 + 3,  Y0 + 2,  12'hFFF);
    probe_a("i_r2_c2", X0 + 10, Y0 + 2,  12'h000);
    probe_a("i_r5_c0", X0 + 8,  Y0 + 5,  12'hFFF);
    probe_a("i_r5_c3", X0 + 11, Y0 + 5,  12'h000);
    probe_a("ul_cell2", X0 + 20, Y0 + 14, 12'h000);
    probe_a("no_ul_cell0", X0 + 0, Y0 + 14, 12'hFFF);

    // Lowercase folds to uppercase (box glyph row 2 = 7E); '{' is swallowed
    send_a(8'h61);
    check_eq("a_cursor", 32'(cursor_a), 32'd3);
    probe_a("a_folded", X0 + 17, Y0 + 2, 12'h000);
    send_a(8'h7B);
    check_eq("brace_cursor", 32'(cursor_a), 32'd3);

    // Fill the line; the 17th letter is accepted but dropped
    for (int i = 0; i < 12; i++) send_a(8'h42);
    check_eq("cur15", 32'(cursor_a), 32'd15);
    check_eq("not_full", 32'(full_a), 32'd0);
    send_a(8'h42);
    check_eq("full_set", 32'(full_a), 32'd1);
    send_a(8'h43);
    check_eq("drop_cursor", 32'(cursor_a), 32'd16);
    check_eq("drop_ready", 32'(ready_a), 32'd1);
    probe_a("no_ul_full", X0 + 120, Y0 + 14, 12'hFFF);
    probe_a("cell15_b",   X0 + 121, Y0 + 2,  12'h000);

    // Backspace from full
    send_a(8'h08);
    check_eq("bs_cursor", 32'(cursor_a), 32'd15);
    check_eq("bs_full",   32'(full_a),   32'd0);
    probe_a("bs_blank", X0 + 121, Y0 + 2,  12'hFFF);
    probe_a("bs_ul",    X0 + 120, Y0 + 14, 12'h000);

    // Enter clears the line
    send_a(8'h0D);
    wait_sweep_a("cr_ready");
    check_eq("cr_cursor", 32'(cursor_a), 32'd0);
    probe_a("cr_blank", X0 + 10, Y0 + 2, 12'hFFF);

    // Backspace at 0, then A,B,BS
    send_a(8'h08);
    check_eq("bs0_cursor", 32'(cursor_a), 32'd0);
    send_a(8'h41);
    send_a(8'h42);
    send_a(8'h08);
    check_eq("ab_bs_cursor", 32'(cursor_a), 32'd1);
    probe_a("ab_bs_cell1", X0 + 9, Y0 + 2, 12'hFFF);
    probe_a("ab_bs_cell0", X0 + 1, Y0 + 2, 12'h000);

    // Reset in the middle of a sweep restarts it from cell 0
    send_a(8'h0D);
    tick(5);
    reset_a = 1'b1;
    valid_a = 1'b1;
    data_a  = 8'h51;
    tick(1);
    reset_a = 1'b0;
    wait_sweep_a("rst_mid_ready");
    check_eq("rst_mid_cursor", 32'(cursor_a), 32'd0);

    // Blanking latency
    x_a = 10'(X0);
    y_a = 10'(Y0);
    tick(3);
    check_eq("vid_on", 32'(rgb_a), 32'hFFF);
    video_on_a = 1'b0;
    tick(1);
    check_eq("vid_lat1", 32'(rgb_a), 32'hFFF);
    tick(1);
    check_eq("vid_off", 32'(rgb_a), 32'h0);

    // Scaled instance: 2x pixels, blink every 4 clocks
    reset_b = 1'b0;
    tick(20);
    check_eq("b_ready", 32'(ready_b), 32'd1);
    x_b = 10'(X0 + 16);
    y_b = 10'(Y0 + 30);
    valid_b = 1'b1;
    data_b  = 8'h48;
    tick(1);
    valid_b = 1'b0;
    check_eq("b_cursor", 32'(cursor_b), 32'd1);
    check_eq("b_full",   32'(full_b),   32'd0);
    for (int m = 1; m <= 13; m++) begin
      tick(1);
      if (m >= 2) check_eq("blink", 32'(rgb_b), ((((m - 2) / 4) % 2) == 0) ? 32'h000 : 32'hFFF);
    end
    probe_b("s_origin",   X0,     Y0,     12'hFFF);
    probe_b("s_origin11", X0 + 1, Y0 + 1, 12'hFFF);
    probe_b("s_h_c1a",    X0 + 2, Y0 + 4, 12'h000);
    probe_b("s_h_c1b",    X0 + 3, Y0 + 5, 12'h000);
    probe_b("s_h_c2",     X0 + 4, Y0 + 4, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
